// File: rtl/reg_bank_arbiter_pkg.sv
// ============================================================================
//  Module      : reg_arb_pkg
//  Description : Shared defaults, width helper and FSM state type for the
//                round-robin register-bank arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package reg_arb_pkg;

    localparam int NREQ_DEF = 4;
    localparam int DW_DEF   = 8;
    localparam int NREG_DEF = 4;

    // Index width for n items; never less than one bit so ports stay legal
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int AW_DEF = idx_width(NREG_DEF);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reg_bank_arbiter_if.sv
// ============================================================================
//  Module      : reg_bank_arbiter_if
//  Description : Requester/bank bus bundle. Requesters drive the master side,
//                the arbiter sits on the slave side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_bank_arbiter_if
    import reg_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF
);
    localparam int AW = idx_width(NREG);

    logic [NREQ-1:0]      req;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic [NREG*DW-1:0]   reg_q;

    modport master (
        output req, req_addr, req_data,
        input  gnt, busy, reg_q
    );

    modport slave (
        input  req, req_addr, req_data,
        output gnt, busy, reg_q
    );

endinterface

`default_nettype wire

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Returns the first set
//                request bit at or above ptr, wrapping from NREQ-1 to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            valid
);

    // One spare bit so ptr + offset cannot overflow before the wrap
    logic [PW:0]   sum;
    logic [PW-1:0] cand;

    // Scan offsets 0..NREQ-1 from ptr; the first hit wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        sum    = '0;
        cand   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            cand = sum[PW-1:0];
            if (!valid && req[cand]) begin
                valid  = 1'b1;
                winner = cand;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
// ============================================================================
//  Module      : reg_bank_arbiter
//  Description : Round-robin arbiter granting one requester at a time write
//                access to a bank of NREG registers. Two-state FSM: IDLE
//                arbitrates and latches the winner, WRITE grants and writes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int NREG = NREG_DEF
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic           clr,
    reg_bank_arbiter_if.slave   bus
);

    localparam int AW = idx_width(NREG);
    localparam int PW = idx_width(NREQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic [PW-1:0]   win_q;
    logic            arb_valid;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   data_q;
    logic [NREQ-1:0] gnt_w;

    logic [AW-1:0]   addr_lane [NREQ];
    logic [DW-1:0]   data_lane [NREQ];

    // Split the flat request buses into per-requester lanes
    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign addr_lane[i] = bus.req_addr[i*AW +: AW];
        assign data_lane[i] = bus.req_data[i*DW +: DW];
    end

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .req    (bus.req),
        .ptr    (ptr),
        .winner (win),
        .valid  (arb_valid)
    );

    // State register; reset aborts any write in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: IDLE waits for any request, WRITE always lasts one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arb_valid) state_next = WRITE;
            WRITE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the winner's address/data on the arbitration cycle and advance ptr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            win_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else if (state == IDLE && arb_valid) begin
            win_q  <= win;
            addr_q <= addr_lane[win];
            data_q <= data_lane[win];
            ptr    <= (win == LAST_IDX) ? '0 : win + 1'b1;
        end
    end

    // Grant is a one-cycle pulse for the latched winner while in WRITE;
    // clr does not mask it so a cleared request is still consumed
    always_comb begin
        gnt_w = '0;
        if (state == WRITE) begin
            gnt_w[win_q] = 1'b1;
        end
    end

    assign bus.gnt  = gnt_w;
    assign bus.busy = (state == WRITE);

    // Register bank: clr wins over the load at the edge ending WRITE
    for (genvar k = 0; k < NREG; k++) begin : g_bank
        logic [DW-1:0] q;
        logic          load;

        assign load = (state == WRITE) && (addr_q == AW'(k));

        // Per-register clear/load
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (clr) begin
                q <= '0;
            end else if (load) begin
                q <= data_q;
            end
        end

        assign bus.reg_q[k*DW +: DW] = q;
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_bank_arbiter.sv
// ============================================================================
//  Module      : tb_reg_bank_arbiter
//  Description : Self-checking bench for reg_bank_arbiter: directed scenarios
//                followed by random traffic against a transaction-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_bank_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic clr;

    reg_bank_arbiter_if #(.NREQ(NREQ), .DW(DW), .NREG(NREG)) bus ();

    reg_bank_arbiter #(.NREQ(NREQ), .DW(DW), .NREG(NREG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: bank contents, rotation pointer and the one pending grant
    logic [DW-1:0] m_bank [NREG];
    int            m_ptr;
    int            m_pend;
    int            m_addr;
    logic [DW-1:0] m_data;

    int tick_no = 0;
    int gnt_log [$];
    int gnt_tick [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_bank[k] = '0;
        m_ptr  = 0;
        m_pend = -1;
        m_addr = 0;
        m_data = '0;
    endtask

    // Apply the rules for one clock edge using the inputs present now
    task automatic model_edge();
        bit found;
        if (m_pend >= 0) begin
            if (clr) begin
                for (int k = 0; k < NREG; k++) m_bank[k] = '0;
            end else begin
                m_bank[m_addr] = m_data;
            end
            m_pend = -1;
        end else begin
            if (clr) begin
                for (int k = 0; k < NREG; k++) m_bank[k] = '0;
            end
            found = 1'b0;
            for (int o = 0; o < NREQ; o++) begin
                int idx;
                idx = (m_ptr + o) % NREQ;
                if (!found && bus.req[idx]) begin
                    found  = 1'b1;
                    m_pend = idx;
                    m_addr = int'(bus.req_addr[idx*AW +: AW]);
                    m_data = bus.req_data[idx*DW +: DW];
                    m_ptr  = (idx + 1) % NREQ;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NREQ-1:0] exp_gnt;
        exp_gnt = '0;
        if (m_pend >= 0) exp_gnt[m_pend] = 1'b1;
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(exp_gnt));
        chk({tag, "_busy"}, 64'(bus.busy), 64'(m_pend >= 0));
        for (int k = 0; k < NREG; k++) begin
            chk($sformatf("%s_reg%0d", tag, k), 64'(bus.reg_q[k*DW +: DW]), 64'(m_bank[k]));
        end
    endtask

    // Advance one clock, then check on the falling edge
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        @(negedge clk);
        tick_no++;
        for (int i = 0; i < NREQ; i++) begin
            if (bus.gnt[i]) begin
                gnt_log.push_back(i);
                gnt_tick.push_back(tick_no);
            end
        end
        check_all(tag);
    endtask

    task automatic set_lane(input int i, input bit r, input int a, input logic [DW-1:0] d);
        bus.req[i]               = r;
        bus.req_addr[i*AW +: AW] = AW'(a);
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        clr          = 1'b0;
        bus.req      = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        model_reset();

        // Single write: grant one cycle after request, data visible the cycle after
        do_reset();
        set_lane(0, 1'b1, 2, 8'hA5);
        tick("single_arb");
        chk("single_gnt0", 64'(bus.gnt), 64'h1);
        set_lane(0, 1'b0, 0, 8'h00);
        tick("single_wr");
        chk("single_reg2", 64'(bus.reg_q[2*DW +: DW]), 64'hA5);

        // All four requesting: rotation 0,1,2,3,0 at two-cycle spacing
        do_reset();
        gnt_log.delete();
        gnt_tick.delete();
        for (int i = 0; i < NREQ; i++) set_lane(i, 1'b1, i, 8'(i));
        for (int c = 0; c < 10; c++) tick("rr");
        bus.req = '0;
        chk("rr_count", 64'(gnt_log.size()), 64'd5);
        if (gnt_log.size() == 5) begin
            chk("rr_order0", 64'(gnt_log[0]), 64'd0);
            chk("rr_order1", 64'(gnt_log[1]), 64'd1);
            chk("rr_order2", 64'(gnt_log[2]), 64'd2);
            chk("rr_order3", 64'(gnt_log[3]), 64'd3);
            chk("rr_order4", 64'(gnt_log[4]), 64'd0);
            for (int g = 1; g < 5; g++) chk("rr_spacing", 64'(gnt_tick[g] - gnt_tick[g-1]), 64'd2);
        end
        tick("rr_tail");

        // Same target from two requesters: later grant's data remains
        do_reset();
        gnt_log.delete();
        set_lane(0, 1'b1, 1, 8'h11);
        set_lane(2, 1'b1, 1, 8'h22);
        tick("same_a0");
        set_lane(0, 1'b0, 0, 8'h00);
        tick("same_w0");
        tick("same_a2");
        set_lane(2, 1'b0, 0, 8'h00);
        tick("same_w2");
        chk("same_first", 64'(gnt_log[0]), 64'd0);
        chk("same_second", 64'(gnt_log[1]), 64'd2);
        chk("same_reg1", 64'(bus.reg_q[1*DW +: DW]), 64'h22);

        // clr during WRITE: grant still pulses, bank ends all zero
        set_lane(2, 1'b1, 0, 8'h7F);
        tick("clr_arb");
        set_lane(2, 1'b0, 0, 8'h00);
        clr = 1'b1;
        #1;
        chk("clr_gnt", 64'(bus.gnt), 64'h4);
        tick("clr_wr");
        clr = 1'b0;
        chk("clr_bank", 64'(bus.reg_q), 64'h0);

        // Dropped request before arbitration is ignored
        set_lane(1, 1'b1, 0, 8'h55);
        tick("drop_arb1");
        set_lane(1, 1'b0, 0, 8'h00);
        set_lane(3, 1'b1, 3, 8'hEE);
        tick("drop_wr1");
        set_lane(3, 1'b0, 0, 8'h00);
        gnt_log.delete();
        tick("drop_idle");
        tick("drop_idle2");
        chk("drop_no_gnt", 64'(gnt_log.size()), 64'd0);
        chk("drop_reg3", 64'(bus.reg_q[3*DW +: DW]), 64'(m_bank[3]));

        // Reset asserted mid-WRITE aborts the write immediately
        set_lane(0, 1'b1, 3, 8'h99);
        tick("rst_arb");
        set_lane(0, 1'b0, 0, 8'h00);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_gnt", 64'(bus.gnt), 64'h0);
        chk("rstmid_busy", 64'(bus.busy), 64'h0);
        chk("rstmid_regq", 64'(bus.reg_q), 64'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick("rstmid_after");
        chk("rstmid_no_write", 64'(bus.reg_q[3*DW +: DW]), 64'h0);

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            bus.req      = NREQ'($urandom_range(0, 15));
            bus.req_addr = (NREQ*AW)'($urandom());
            bus.req_data = (NREQ*DW)'($urandom());
            clr          = ($urandom_range(0, 15) == 0);
            tick("rand");
        end
        clr     = 1'b0;
        bus.req = '0;
        tick("final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
